// File: rtl/dpram_ctrl.sv
// Command/response controller in front of a 16-word registered-read dual-port RAM.
// Fills the RAM with INIT_VAL after reset, then serves single-beat writes and reads.
module dpram_ctrl #(
    parameter logic [7:0] INIT_VAL = 8'h00
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_we,
    input  logic [3:0]  cmd_addr,
    input  logic [7:0]  cmd_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [7:0]  rsp_data,
    output logic [3:0]  rsp_addr,
    output logic        mem_enb,
    output logic        mem_wr,
    output logic        mem_rd,
    output logic [15:0] mem_w_addr,
    output logic [15:0] mem_r_addr,
    output logic [7:0]  mem_w_data,
    input  logic [7:0]  mem_r_data,
    output logic        init_done,
    output logic [15:0] wr_cnt,
    output logic [15:0] rd_cnt
);

    typedef enum logic [1:0] {
        INIT,
        RUN,
        RD_WAIT
    } state_t;

    state_t     state;
    state_t     state_nxt;
    logic [3:0] init_ptr;
    logic [3:0] w_addr;
    logic [3:0] r_addr;
    logic       init_last;
    logic       wr_acc;
    logic       rd_acc;
    logic       rsp_hs;
    logic       cap_pend;

    assign init_last  = (init_ptr == 4'hF);
    assign mem_w_addr = {12'h000, w_addr};
    assign mem_r_addr = {12'h000, r_addr};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= INIT;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        cmd_ready = 1'b0;
        wr_acc    = 1'b0;
        rd_acc    = 1'b0;
        rsp_hs    = 1'b0;
        case (state)
            INIT: begin
                if (init_last) state_nxt = RUN;
            end
            RUN: begin
                cmd_ready = 1'b1;
                wr_acc    = cmd_valid & cmd_we;
                rd_acc    = cmd_valid & ~cmd_we;
                if (rd_acc) state_nxt = RD_WAIT;
            end
            RD_WAIT: begin
                rsp_hs = rsp_valid & rsp_ready;
                if (rsp_hs) state_nxt = RUN;
            end
            default: state_nxt = INIT;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            init_ptr   <= '0;
            init_done  <= 1'b0;
            mem_enb    <= 1'b0;
            mem_wr     <= 1'b0;
            mem_rd     <= 1'b0;
            w_addr     <= '0;
            r_addr     <= '0;
            mem_w_data <= '0;
            cap_pend   <= 1'b0;
            rsp_valid  <= 1'b0;
            rsp_data   <= '0;
            rsp_addr   <= '0;
            wr_cnt     <= '0;
            rd_cnt     <= '0;
        end else begin
            mem_enb  <= 1'b0;
            mem_wr   <= 1'b0;
            mem_rd   <= 1'b0;
            // mem_rd was high last cycle, so the RAM has just registered the read word
            cap_pend <= mem_rd;

            if (state == INIT) begin
                mem_enb    <= 1'b1;
                mem_wr     <= 1'b1;
                w_addr     <= init_ptr;
                mem_w_data <= INIT_VAL;
                init_ptr   <= init_ptr + 4'd1;
                if (init_last) init_done <= 1'b1;
            end

            if (wr_acc) begin
                mem_enb    <= 1'b1;
                mem_wr     <= 1'b1;
                w_addr     <= cmd_addr;
                mem_w_data <= cmd_wdata;
                wr_cnt     <= wr_cnt + 16'd1;
            end

            if (rd_acc) begin
                mem_enb  <= 1'b1;
                mem_rd   <= 1'b1;
                r_addr   <= cmd_addr;
                rsp_addr <= cmd_addr;
                rd_cnt   <= rd_cnt + 16'd1;
            end

            if (cap_pend) begin
                rsp_data  <= mem_r_data;
                rsp_valid <= 1'b1;
            end else if (rsp_hs) begin
                rsp_valid <= 1'b0;
            end
        end
    end

endmodule
